// File: rtl/retire_freelist_pkg.sv
// -----------------------------------------------------------------------------
// retire_freelist_pkg
// Shared sizing and types for the physical-register free list and retirement
// map. These are the same WAYS/PRF/REGS/PW values used by the ROB and rename
// map, so all three agree on PRN and ARN widths.
//   WAYS  superscalar width (dispatch and commit ports)
//   PRF   number of physical registers
//   REGS  number of architectural registers
//   FL    free-list depth (PRF - REGS); must be a power of two so the
//         pointers wrap naturally
//   PW    PRN width
// -----------------------------------------------------------------------------
package retire_freelist_pkg;

    localparam int WAYS = 3;
    localparam int PRF  = 64;
    localparam int REGS = 32;
    localparam int FL   = PRF - REGS;
    localparam int PW   = $clog2(PRF);
    localparam int AW   = 5;
    localparam int FLW  = $clog2(FL);
    localparam int NFW  = FLW + 1;

    typedef logic [PW-1:0]  prn_t;
    typedef logic [AW-1:0]  arn_t;
    typedef logic [FLW-1:0] fl_ptr_t;  // wraps mod FL by width alone
    typedef logic [NFW-1:0] fl_cnt_t;  // holds 0..FL inclusive

endpackage

// File: rtl/retire_freelist_rrat.sv
// -----------------------------------------------------------------------------
// rrat_bypass
// Combinational lookup of the PRN each committing way supersedes. Normally that
// is the current architectural mapping, but when an earlier way in the same
// commit group writes the same ARN, the superseded PRN is that way's new PRN
// (the map update has not landed yet).
// Ports:
//   commit_valid  per-way commit valid
//   commit_ARN    per-way destination architectural register
//   commit_PRN    per-way destination physical register
//   rrat          current architectural map (registered, in the top)
//   old_prn       per-way superseded PRN
// -----------------------------------------------------------------------------
module rrat_bypass
    import retire_freelist_pkg::*;
(
    input  logic [WAYS-1:0] commit_valid,
    input  arn_t [WAYS-1:0] commit_ARN,
    input  prn_t [WAYS-1:0] commit_PRN,
    input  prn_t [REGS-1:0] rrat,
    output prn_t [WAYS-1:0] old_prn
);

    always_comb begin
        for (int j = 0; j < WAYS; j++) begin
            // NOTE: every output gets a value before any condition is tested,
            // so no path leaves it unassigned and no latch is inferred.
            old_prn[j] = rrat[commit_ARN[j]];
            // Ascending scan: the youngest earlier writer of this ARN wins.
            for (int i = 0; i < j; i++) begin
                if (commit_valid[i] && (commit_ARN[i] == commit_ARN[j])) begin
                    old_prn[j] = commit_PRN[i];
                end
            end
        end
    end

endmodule

// File: rtl/retire_freelist.sv
// -----------------------------------------------------------------------------
// retire_freelist
// Physical-register free list plus retirement (architectural) map table.
// The free list is a circular buffer of FL PRNs with three pointers:
//   head   next PRN handed to dispatch
//   tail   next slot for a PRN returned by commit
//   retire oldest in-flight allocation not yet committed
// Slots [retire, head) are in flight, [head, tail) are free. On proc_nuke the
// in-flight span is reclaimed by moving head back to retire.
// Ports:
//   clock, reset     clock; synchronous active-high reset
//   alloc_req        per-way PRN request from dispatch
//   alloc_prn        per-way granted PRN (combinational)
//   alloc_valid      per-way grant (combinational)
//   commit_valid     per-way ROB commit valid
//   commit_ARN/PRN   per-way committed destination mapping
//   proc_nuke        mispredict flush
//   freed_prn        per-way superseded PRN (combinational)
//   freed_valid      per-way freed_prn valid
//   num_free         registered free PRN count
//   arch_map_out     registered architectural map
// -----------------------------------------------------------------------------
module retire_freelist
    import retire_freelist_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [WAYS-1:0] alloc_req,
    output prn_t [WAYS-1:0] alloc_prn,
    output logic [WAYS-1:0] alloc_valid,
    input  logic [WAYS-1:0] commit_valid,
    input  arn_t [WAYS-1:0] commit_ARN,
    input  prn_t [WAYS-1:0] commit_PRN,
    input  logic            proc_nuke,
    output prn_t [WAYS-1:0] freed_prn,
    output logic [WAYS-1:0] freed_valid,
    output fl_cnt_t         num_free,
    output prn_t [REGS-1:0] arch_map_out
);

    prn_t            fl [FL];
    fl_ptr_t         head;
    fl_ptr_t         tail;
    fl_ptr_t         retire;
    prn_t [REGS-1:0] rrat;

    prn_t [WAYS-1:0] old_prn;
    fl_cnt_t         grants;
    fl_cnt_t         commits;
    fl_cnt_t         req_cnt;
    fl_ptr_t         commit_off [WAYS];

    rrat_bypass u_rrat_bypass (
        .commit_valid (commit_valid),
        .commit_ARN   (commit_ARN),
        .commit_PRN   (commit_PRN),
        .rrat         (rrat),
        .old_prn      (old_prn)
    );

    // Allocation: way i takes the slot after all lower requesting ways. Grants
    // therefore form a prefix of the requests, so head advances by the grant
    // count without leaving holes.
    always_comb begin
        // NOTE: running counts use blocking assignments so each loop iteration
        // sees the total accumulated by the lower ways in the same evaluation.
        grants  = '0;
        req_cnt = '0;
        for (int i = 0; i < WAYS; i++) begin
            alloc_prn[i]   = fl[head + fl_ptr_t'(req_cnt)];
            alloc_valid[i] = alloc_req[i] && (req_cnt < num_free) && !proc_nuke && !reset;
            grants  = grants + fl_cnt_t'(alloc_valid[i]);
            req_cnt = req_cnt + fl_cnt_t'(alloc_req[i]);
        end
    end

    // Commit: each valid way returns its superseded PRN at the next tail slot.
    always_comb begin
        commits = '0;
        for (int j = 0; j < WAYS; j++) begin
            commit_off[j]  = fl_ptr_t'(commits);
            freed_valid[j] = commit_valid[j] && !reset;
            freed_prn[j]   = commit_valid[j] ? old_prn[j] : '0;
            commits = commits + fl_cnt_t'(commit_valid[j]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the free-list storage is reset, not just the pointers: the
            // initial contents (REGS..PRF-1) are the PRNs not covered by the
            // identity map and are handed out straight after reset.
            for (int i = 0; i < FL; i++) begin
                fl[i] <= prn_t'(REGS + i);
            end
            for (int i = 0; i < REGS; i++) begin
                rrat[i] <= prn_t'(i);
            end
            head     <= '0;
            tail     <= '0;
            retire   <= '0;
            num_free <= fl_cnt_t'(FL);
        end else begin
            // Same-ARN commits in one group: the later way's update is issued
            // last and wins, matching program order.
            for (int j = 0; j < WAYS; j++) begin
                if (commit_valid[j]) begin
                    fl[tail + commit_off[j]] <= old_prn[j];
                    rrat[commit_ARN[j]]      <= commit_PRN[j];
                end
            end
            tail   <= tail + fl_ptr_t'(commits);
            retire <= retire + fl_ptr_t'(commits);
            if (proc_nuke) begin
                // Everything past the post-commit retire pointer was
                // speculative; tail - retire == 0 mod FL, so all FL are free.
                head     <= retire + fl_ptr_t'(commits);
                num_free <= fl_cnt_t'(FL);
            end else begin
                head     <= head + fl_ptr_t'(grants);
                num_free <= num_free - grants + commits;
            end
        end
    end

    assign arch_map_out = rrat;

endmodule

// File: tb/tb_retire_freelist.sv
// -----------------------------------------------------------------------------
// tb_retire_freelist
// Reference model: the free list is a queue of PRNs in hand-out order, the
// in-flight window is a queue of (ARN, PRN) instructions in allocation order,
// and the architectural map is a plain array. Commits pop the oldest in-flight
// instructions, so the bench only ever commits PRNs it was actually granted.
// -----------------------------------------------------------------------------
module tb_retire_freelist;
    import retire_freelist_pkg::*;

    logic            clock;
    logic            reset;
    logic [WAYS-1:0] alloc_req;
    prn_t [WAYS-1:0] alloc_prn;
    logic [WAYS-1:0] alloc_valid;
    logic [WAYS-1:0] commit_valid;
    arn_t [WAYS-1:0] commit_ARN;
    prn_t [WAYS-1:0] commit_PRN;
    logic            proc_nuke;
    prn_t [WAYS-1:0] freed_prn;
    logic [WAYS-1:0] freed_valid;
    fl_cnt_t         num_free;
    prn_t [REGS-1:0] arch_map_out;

    retire_freelist dut (
        .clock        (clock),
        .reset        (reset),
        .alloc_req    (alloc_req),
        .alloc_prn    (alloc_prn),
        .alloc_valid  (alloc_valid),
        .commit_valid (commit_valid),
        .commit_ARN   (commit_ARN),
        .commit_PRN   (commit_PRN),
        .proc_nuke    (proc_nuke),
        .freed_prn    (freed_prn),
        .freed_valid  (freed_valid),
        .num_free     (num_free),
        .arch_map_out (arch_map_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int arn;
        int prn;
    } rob_e;

    int   free_q [$];
    rob_e rob_q  [$];
    int   arch   [REGS];

    int n_checks = 0;
    int n_fail   = 0;

    // Per-cycle stimulus knobs.
    logic [WAYS-1:0] s_req;
    logic [WAYS-1:0] s_cmask;
    logic            s_nuke;
    int              s_arn_force;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] arch_vec();
        prn_t [REGS-1:0] v;
        for (int i = 0; i < REGS; i++) v[i] = prn_t'(arch[i]);
        return v;
    endfunction

    function automatic logic [191:0] ident_vec();
        prn_t [REGS-1:0] v;
        for (int i = 0; i < REGS; i++) v[i] = prn_t'(i);
        return v;
    endfunction

    task automatic model_reset();
        free_q.delete();
        rob_q.delete();
        for (int i = 0; i < FL; i++) free_q.push_back(REGS + i);
        for (int i = 0; i < REGS; i++) arch[i] = i;
    endtask

    // Reset is held for two edges with allocation, commit and nuke all active
    // to show reset dominates them.
    task automatic do_reset();
        reset        = 1'b1;
        alloc_req    = '1;
        proc_nuke    = 1'b1;
        commit_valid = '1;
        for (int j = 0; j < WAYS; j++) begin
            commit_ARN[j] = arn_t'($urandom);
            commit_PRN[j] = prn_t'($urandom);
        end
        @(posedge clock); #4;
        check("alloc_valid_in_reset", alloc_valid, 0);
        @(posedge clock); #1;
        reset        = 1'b0;
        proc_nuke    = 1'b0;
        commit_valid = '0;
        model_reset();
        #1;
        check("reset_num_free", num_free, 32);
        check("reset_alloc_prn0", alloc_prn[0], 32);
        check("reset_arch_map", arch_map_out, ident_vec());
        check("reset_freed_valid", freed_valid, 0);
    endtask

    // One clock: drive, check combinational and registered outputs at the
    // falling edge, advance the model, then step past the rising edge.
    task automatic cycle();
        logic [WAYS-1:0] exp_av;
        logic [WAYS-1:0] exp_fv;
        logic [WAYS-1:0] cv;
        int   c_arn [WAYS];
        int   c_prn [WAYS];
        int   fq    [$];
        int   newq  [$];
        int   k;
        int   old;
        int   p;
        rob_e e;

        alloc_req = s_req;
        proc_nuke = s_nuke;
        cv = '0;
        for (int j = 0; j < WAYS; j++) begin
            if (s_cmask[j] && (rob_q.size() > 0)) begin
                e = rob_q.pop_front();
                cv[j]    = 1'b1;
                c_arn[j] = (s_arn_force >= 0) ? s_arn_force : e.arn;
                c_prn[j] = e.prn;
                commit_ARN[j] = arn_t'(c_arn[j]);
                commit_PRN[j] = prn_t'(c_prn[j]);
            end else begin
                c_arn[j] = 0;
                c_prn[j] = 0;
                commit_ARN[j] = arn_t'($urandom);
                commit_PRN[j] = prn_t'($urandom);
            end
        end
        commit_valid = cv;
        #4;

        check("num_free", num_free, free_q.size());
        check("arch_map_out", arch_map_out, arch_vec());

        exp_av = '0;
        k = 0;
        for (int i = 0; i < WAYS; i++) begin
            if (s_req[i]) begin
                if (!s_nuke && (k < free_q.size())) begin
                    exp_av[i] = 1'b1;
                    check("alloc_prn", alloc_prn[i], free_q[k]);
                end
                k++;
            end
        end
        check("alloc_valid", alloc_valid, exp_av);

        // Walking commits in order through the map gives the same-ARN bypass.
        exp_fv = '0;
        for (int j = 0; j < WAYS; j++) begin
            if (cv[j]) begin
                old = arch[c_arn[j]];
                exp_fv[j] = 1'b1;
                check("freed_prn", freed_prn[j], old);
                arch[c_arn[j]] = c_prn[j];
                fq.push_back(old);
            end
        end
        check("freed_valid", freed_valid, exp_fv);

        if (s_nuke) begin
            // Squashed allocations come back first, in allocation order.
            foreach (rob_q[n]) newq.push_back(rob_q[n].prn);
            foreach (free_q[n]) newq.push_back(free_q[n]);
            foreach (fq[n]) newq.push_back(fq[n]);
            free_q = newq;
            rob_q.delete();
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                if (exp_av[i]) begin
                    p = free_q.pop_front();
                    rob_q.push_back('{arn: int'($urandom_range(REGS - 1, 1)), prn: p});
                end
            end
            foreach (fq[n]) free_q.push_back(fq[n]);
        end

        @(posedge clock); #1;
    endtask

    initial begin
        s_req = '0; s_cmask = '0; s_nuke = 1'b0; s_arn_force = -1;
        alloc_req = '0; commit_valid = '0; commit_ARN = '0; commit_PRN = '0;
        proc_nuke = 1'b0; reset = 1'b1;

        do_reset();

        // Three-wide allocation from a fresh list.
        s_req = 3'b111; cycle();
        check("num_free_after_3", num_free, 29);

        // Non-contiguous request.
        s_req = 3'b101; cycle();
        check("num_free_after_101", num_free, 27);

        // Two commits to x5 in one group: second frees the first's PRN.
        s_req = 3'b000; s_cmask = 3'b011; s_arn_force = 5; cycle();
        check("rrat_x5_bypass", arch_map_out[5], 33);
        check("num_free_after_commit", num_free, 29);
        s_cmask = 3'b000; s_arn_force = -1;

        // Drain to a single free PRN, then over-request.
        while (free_q.size() >= 3) begin
            s_req = 3'b111; cycle();
        end
        if (free_q.size() == 2) begin
            s_req = 3'b001; cycle();
        end
        check("drained_num_free", num_free, 1);
        s_req = 3'b111; cycle();
        check("empty_num_free", num_free, 0);

        // Alloc/commit traffic through the pointer wrap.
        for (int c = 0; c < 120; c++) begin
            s_req = WAYS'($urandom); s_cmask = WAYS'($urandom); cycle();
        end

        // Flush with a same-cycle commit.
        do_reset();
        s_cmask = 3'b000; s_req = 3'b111; cycle(); cycle();
        s_req = 3'b000; s_cmask = 3'b001; s_arn_force = 1; cycle();
        s_req = 3'b111; s_arn_force = 2; s_nuke = 1'b1; cycle();
        s_cmask = 3'b000; s_arn_force = -1; s_nuke = 1'b0;
        check("nuke_num_free", num_free, 32);
        check("nuke_arch_x1", arch_map_out[1], 32);
        check("nuke_arch_x2", arch_map_out[2], 33);
        alloc_req = 3'b111; #1;
        check("nuke_realloc0", alloc_prn[0], 34);
        check("nuke_realloc1", alloc_prn[1], 35);
        check("nuke_realloc2", alloc_prn[2], 36);

        // Random traffic with occasional flushes and a mid-burst reset.
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) do_reset();
            s_req   = WAYS'($urandom);
            s_cmask = WAYS'($urandom);
            s_nuke  = ($urandom_range(39, 0) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
